// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access length encodings,
// FSM state type and small address helpers.
package data_mem_responder_pkg;

    // Access length encodings as driven by the load/store unit
    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    // Half on an odd byte or word off a word boundary
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] lo);
        return ((len == LEN_HALF) && lo[0]) || ((len == LEN_WORD) && (lo != 2'b00));
    endfunction

    // Force the low address bits onto the natural boundary of the access
    function automatic logic [1:0] align_low(input logic [1:0] len, input logic [1:0] lo);
        logic [1:0] res;
        res = lo;
        if (len == LEN_HALF) res = {lo[1], 1'b0};
        if (len == LEN_WORD) res = 2'b00;
        return res;
    endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Little-endian lane steering for a 32-bit word: byte enables and replicated
// store data for writes, lane extraction with sign/zero extension for reads.
// A length of LEN_NONE enables no store lanes and reads the full word.
module data_mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  length,
    input  logic [31:0] write_data,
    input  logic        read_signed,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_word,
    output logic [31:0] read_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane selection and extension, purely combinational
    always_comb begin
        byte_en    = 4'b0000;
        write_word = write_data;
        read_data  = read_word;
        lane_byte  = read_word[{addr_lo, 3'b000} +: 8];
        lane_half  = addr_lo[1] ? read_word[31:16] : read_word[15:0];
        case (length)
            LEN_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                write_word = {4{write_data[7:0]}};
                read_data  = {{24{read_signed & lane_byte[7]}}, lane_byte};
            end
            LEN_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                write_word = {2{write_data[15:0]}};
                read_data  = {{16{read_signed & lane_half[15]}}, lane_half};
            end
            LEN_WORD: begin
                byte_en = 4'b1111;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store interface. One request per
// handshake, fixed wait-state latency, response held until taken.
// Optional: define DATA_MEM_MISALIGN_TRAP_EN to reject misaligned accesses
// with MEM_error instead of silently aligning them.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset_n,
    input  logic        MEM_req_valid,
    output logic        MEM_req_ready,
    input  logic        MEM_req_write,
    input  logic [31:0] MEM_address,
    input  logic [31:0] MEM_write_data,
    input  logic [1:0]  MEM_write_length,
    input  logic [1:0]  MEM_read_length,
    input  logic        MEM_read_signed,
    output logic        MEM_rsp_valid,
    input  logic        MEM_rsp_ready,
    output logic [31:0] MEM_read_data,
    output logic        MEM_error
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_W = IDX_W + 2;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [1:0]          len_q;
    logic                signed_q;
    logic                write_q;
    logic [31:0]         rdata_q;
    logic                req_ready_q;
    logic                rsp_valid_q;

    logic [31:0]         mem [DEPTH_WORDS];

    logic [1:0]          req_len;
    logic [1:0]          lane_lo;
    logic                trap;
    logic                perform;
    logic                mem_we;
    logic [IDX_W-1:0]    word_idx;
    logic [31:0]         mem_rword;
    logic [3:0]          byte_en;
    logic [31:0]         write_word;
    logic [31:0]         load_data;

    // Address bits above the array wrap window are deliberately ignored
    logic unused_addr_hi;
    assign unused_addr_hi = ^MEM_address[31:ADDR_W];

    // A single effective length per request: the store length for stores,
    // the load length (00 meaning word) for loads
    assign req_len = MEM_req_write ? MEM_write_length
                   : ((MEM_read_length == LEN_NONE) ? LEN_WORD : MEM_read_length);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign trap    = is_misaligned(len_q, addr_q[1:0]);
    assign lane_lo = addr_q[1:0];
`else
    assign trap    = 1'b0;
    assign lane_lo = align_low(len_q, addr_q[1:0]);
`endif

    assign word_idx  = addr_q[ADDR_W-1:2];
    assign mem_rword = mem[word_idx];
    assign perform   = (state_q == StWait) && (cnt_q == 4'd0);
    assign mem_we    = perform && write_q && !trap;

    data_mem_lane_align u_lane_align (
        .addr_lo     (lane_lo),
        .length      (len_q),
        .write_data  (wdata_q),
        .read_signed (signed_q),
        .read_word   (mem_rword),
        .byte_en     (byte_en),
        .write_word  (write_word),
        .read_data   (load_data)
    );

    // Storage array: byte-lane writes on the perform edge, never reset
    always_ff @(posedge SYS_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= write_word[8*b +: 8];
            end
        end
    end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic error_q;
`endif

    // Request/wait/response sequencing with registered handshake outputs
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_q       <= LEN_NONE;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
            error_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (MEM_req_valid) begin
                        addr_q      <= MEM_address[ADDR_W-1:0];
                        wdata_q     <= MEM_write_data;
                        len_q       <= req_len;
                        signed_q    <= MEM_read_signed;
                        write_q     <= MEM_req_write;
                        cnt_q       <= 4'(WAIT_CYCLES - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q     <= (write_q || trap) ? 32'd0 : load_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
                        error_q     <= trap;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (MEM_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_req_ready = req_ready_q;
    assign MEM_rsp_valid = rsp_valid_q;
    assign MEM_read_data = rdata_q;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign MEM_error = error_q;
`else
    assign MEM_error = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized accesses checked against a byte-array reference model.
module tb_data_mem_responder;

    localparam int W = 2;
    localparam int D = 1024;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset_n = 1'b0;
    logic        MEM_req_valid = 1'b0;
    logic        MEM_req_ready;
    logic        MEM_req_write = 1'b0;
    logic [31:0] MEM_address = '0;
    logic [31:0] MEM_write_data = '0;
    logic [1:0]  MEM_write_length = '0;
    logic [1:0]  MEM_read_length = '0;
    logic        MEM_read_signed = 1'b0;
    logic        MEM_rsp_valid;
    logic        MEM_rsp_ready = 1'b0;
    logic [31:0] MEM_read_data;
    logic        MEM_error;

    int tests = 0;
    int fails = 0;

    logic [7:0] mdl   [D*4];
    bit         known [D*4];

    always #5 SYS_clk = ~SYS_clk;

    data_mem_responder #(
        .DEPTH_WORDS (D),
        .WAIT_CYCLES (W)
    ) dut (
        .SYS_clk          (SYS_clk),
        .SYS_reset_n      (SYS_reset_n),
        .MEM_req_valid    (MEM_req_valid),
        .MEM_req_ready    (MEM_req_ready),
        .MEM_req_write    (MEM_req_write),
        .MEM_address      (MEM_address),
        .MEM_write_data   (MEM_write_data),
        .MEM_write_length (MEM_write_length),
        .MEM_read_length  (MEM_read_length),
        .MEM_read_signed  (MEM_read_signed),
        .MEM_rsp_valid    (MEM_rsp_valid),
        .MEM_rsp_ready    (MEM_rsp_ready),
        .MEM_read_data    (MEM_read_data),
        .MEM_error        (MEM_error)
    );

    // Reference model: memory as a flat byte array addressed modulo its size
    function automatic void model_access(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [1:0] wl,
                                         input logic [1:0] rl, input logic sg,
                                         output logic [31:0] ed, output logic ee,
                                         output bit ek);
        int a;
        int n;
        logic [1:0] len;
        logic [31:0] v;
        bit mis;
        a   = int'(addr % 32'(D*4));
        len = wr ? wl : ((rl == 2'b00) ? 2'b11 : rl);
        n   = (len == 2'b01) ? 1 : (len == 2'b10) ? 2 : (len == 2'b11) ? 4 : 0;
        ed  = 32'd0;
        ee  = 1'b0;
        ek  = 1'b1;
        mis = (n > 1) && ((a % n) != 0);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        if (mis) begin
            ee = 1'b1;
            return;
        end
`else
        if (mis) a = a - (a % n);
`endif
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                mdl[a+i]   = wd[8*i +: 8];
                known[a+i] = 1'b1;
            end
            return;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            v[8*i +: 8] = mdl[a+i];
            if (!known[a+i]) ek = 1'b0;
        end
        if (sg && n == 1 && v[7])  v[31:8]  = '1;
        if (sg && n == 2 && v[15]) v[31:16] = '1;
        ed = v;
    endfunction

    // Drive one request, wait for its response; lat counts the acceptance edge as 1
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] wl, input logic [1:0] rl, input logic sg,
                          input bit release_rsp,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic [31:0] ed, output logic ee, output bit ek);
        int guard;
        model_access(wr, addr, wd, wl, rl, sg, ed, ee, ek);
        @(negedge SYS_clk);
        MEM_req_write    = wr;
        MEM_address      = addr;
        MEM_write_data   = wd;
        MEM_write_length = wl;
        MEM_read_length  = rl;
        MEM_read_signed  = sg;
        MEM_req_valid    = 1'b1;
        guard = 0;
        while (!MEM_req_ready && guard < 50) begin
            @(negedge SYS_clk);
            guard++;
        end
        @(posedge SYS_clk);
        #1;
        MEM_req_valid = 1'b0;
        lat = 1;
        while (!MEM_rsp_valid && lat < 50) begin
            @(posedge SYS_clk);
            #1;
            lat++;
        end
        rd = MEM_read_data;
        er = MEM_error;
        if (release_rsp) begin
            MEM_rsp_ready = 1'b1;
            @(posedge SYS_clk);
            #1;
            MEM_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        SYS_reset_n = 1'b0;
        #12;
        tests++;
        if (MEM_req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_req_ready got %0b exp 1", MEM_req_ready);
        end
        tests++;
        if (MEM_rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_rsp_valid got %0b exp 0", MEM_rsp_valid);
        end
        tests++;
        if (MEM_read_data !== 32'd0) begin
            fails++; $display("FAIL reset_read_data got %h exp 0", MEM_read_data);
        end
        tests++;
        if (MEM_error !== 1'b0) begin
            fails++; $display("FAIL reset_error got %0b exp 0", MEM_error);
        end
        @(negedge SYS_clk);
        SYS_reset_n = 1'b1;
    endtask

    task automatic test_basic_access();
        logic [31:0] rd, ed;
        logic er, ee;
        bit ek;
        int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 2'b00, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (lat !== W + 1) begin
            fails++; $display("FAIL store_latency got %0d exp %0d", lat, W + 1);
        end
        tests++;
        if (rd !== 32'd0) begin
            fails++; $display("FAIL store_read_data got %h exp 0", rd);
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b00, 2'b11, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (rd !== 32'hDEADBEEF) begin
            fails++; $display("FAIL load_word got %h exp deadbeef", rd);
        end
        tests++;
        if (lat !== W + 1) begin
            fails++; $display("FAIL load_latency got %0d exp %0d", lat, W + 1);
        end
        do_req(1'b1, 32'h13, 32'h0000007F, 2'b01, 2'b00, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        do_req(1'b0, 32'h13, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (rd !== 32'h0000007F) begin
            fails++; $display("FAIL load_byte_signed_pos got %h exp 0000007f", rd);
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (rd !== 32'h7FADBEEF) begin
            fails++; $display("FAIL load_word_after_byte got %h exp 7fadbeef", rd);
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (rd !== 32'hFFFFFFEF) begin
            fails++; $display("FAIL load_byte_signed_neg got %h exp ffffffef", rd);
        end
        do_req(1'b0, 32'h12, 32'h0, 2'b00, 2'b10, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (rd !== 32'h00007FAD) begin
            fails++; $display("FAIL load_half_unsigned got %h exp 00007fad", rd);
        end
    endtask

    task automatic test_rsp_hold();
        logic [31:0] rd, ed;
        logic er, ee;
        bit ek;
        int lat;
        do_req(1'b0, 32'h10, 32'h0, 2'b00, 2'b11, 1'b0, 1'b0, rd, er, lat, ed, ee, ek);
        for (int i = 0; i < 5; i++) begin
            @(posedge SYS_clk);
            #1;
            tests++;
            if (MEM_rsp_valid !== 1'b1 || MEM_read_data !== rd || MEM_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_stable cyc %0d got valid=%0b data=%h ready=%0b exp 1 %h 0",
                         i, MEM_rsp_valid, MEM_read_data, MEM_req_ready, rd);
            end
        end
        MEM_rsp_ready = 1'b1;
        @(posedge SYS_clk);
        #1;
        MEM_rsp_ready = 1'b0;
        tests++;
        if (MEM_rsp_valid !== 1'b0 || MEM_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_release got valid=%0b ready=%0b exp 0 1",
                     MEM_rsp_valid, MEM_req_ready);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, ed, exp_word;
        logic er, ee, exp_err;
        bit ek;
        int lat;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        exp_err  = 1'b1;
        exp_word = 32'h7FADBEEF;
`else
        exp_err  = 1'b0;
        exp_word = 32'h12345678;
`endif
        do_req(1'b1, 32'h11, 32'h12345678, 2'b11, 2'b00, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (er !== exp_err) begin
            fails++; $display("FAIL misalign_error got %0b exp %0b", er, exp_err);
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b00, 2'b11, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (rd !== exp_word) begin
            fails++; $display("FAIL misalign_word got %h exp %h", rd, exp_word);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd, ed;
        logic er, ee;
        bit ek;
        int lat;
        do_req(1'b1, 32'h20, 32'h0BADCAFE, 2'b11, 2'b00, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        @(negedge SYS_clk);
        MEM_req_write    = 1'b1;
        MEM_address      = 32'h20;
        MEM_write_data   = 32'hCAFEF00D;
        MEM_write_length = 2'b11;
        MEM_req_valid    = 1'b1;
        @(posedge SYS_clk);
        #1;
        MEM_req_valid = 1'b0;
        SYS_reset_n   = 1'b0;
        #1;
        tests++;
        if (MEM_req_ready !== 1'b1 || MEM_rsp_valid !== 1'b0 ||
            MEM_read_data !== 32'd0 || MEM_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs got ready=%0b valid=%0b data=%h err=%0b exp 1 0 0 0",
                     MEM_req_ready, MEM_rsp_valid, MEM_read_data, MEM_error);
        end
        @(negedge SYS_clk);
        @(negedge SYS_clk);
        SYS_reset_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 2'b00, 2'b11, 1'b0, 1'b1, rd, er, lat, ed, ee, ek);
        tests++;
        if (rd !== 32'h0BADCAFE) begin
            fails++; $display("FAIL reset_mid_old_data got %h exp 0badcafe", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed;
        logic ee;
        bit ek;
        int cyc;
        int guard;
        model_access(1'b0, 32'h10, 32'h0, 2'b00, 2'b11, 1'b0, ed, ee, ek);
        @(negedge SYS_clk);
        MEM_req_write   = 1'b0;
        MEM_address     = 32'h10;
        MEM_read_length = 2'b11;
        MEM_read_signed = 1'b0;
        MEM_req_valid   = 1'b1;
        @(posedge SYS_clk);
        #1;
        cyc = 0;
        while (!MEM_rsp_valid && cyc < 50) begin
            @(posedge SYS_clk);
            #1;
            cyc++;
        end
        MEM_rsp_ready = 1'b1;
        @(posedge SYS_clk);
        #1;
        cyc++;
        MEM_rsp_ready = 1'b0;
        tests++;
        if (MEM_rsp_valid !== 1'b0 || MEM_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_retire got valid=%0b ready=%0b exp 0 1",
                     MEM_rsp_valid, MEM_req_ready);
        end
        @(posedge SYS_clk);
        #1;
        cyc++;
        MEM_req_valid = 1'b0;
        tests++;
        if (MEM_req_ready !== 1'b0 || cyc !== W + 2) begin
            fails++;
            $display("FAIL b2b_accept got ready=%0b period=%0d exp 0 %0d",
                     MEM_req_ready, cyc, W + 2);
        end
        guard = 0;
        while (!MEM_rsp_valid && guard < 50) begin
            @(posedge SYS_clk);
            #1;
            guard++;
        end
        tests++;
        if (MEM_rsp_valid !== 1'b1 || MEM_read_data !== ed) begin
            fails++;
            $display("FAIL b2b_second_rsp got valid=%0b data=%h exp 1 %h",
                     MEM_rsp_valid, MEM_read_data, ed);
        end
        MEM_rsp_ready = 1'b1;
        @(posedge SYS_clk);
        #1;
        MEM_rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rd, ed, addr;
        logic er, ee;
        bit ek;
        int lat;
        logic wr;
        logic [1:0] wl, rl;
        logic sg;
        for (int w = 0; w < 64; w++) begin
            do_req(1'b1, 32'(w * 4), $urandom, 2'b11, 2'b00, 1'b0, 1'b1,
                   rd, er, lat, ed, ee, ek);
        end
        for (int i = 0; i < 150; i++) begin
            wr   = 1'($urandom % 2);
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            wl   = 2'($urandom % 4);
            rl   = 2'($urandom % 4);
            sg   = 1'($urandom % 2);
            do_req(wr, addr, $urandom, wl, rl, sg, 1'b1, rd, er, lat, ed, ee, ek);
            if (ek) begin
                tests++;
                if (rd !== ed) begin
                    fails++;
                    $display("FAIL rand_data op %0d wr=%0b addr=%h wl=%0d rl=%0d sg=%0b got %h exp %h",
                             i, wr, addr, wl, rl, sg, rd, ed);
                end
            end
            tests++;
            if (er !== ee) begin
                fails++;
                $display("FAIL rand_error op %0d addr=%h got %0b exp %0b", i, addr, er, ee);
            end
            tests++;
            if (lat !== W + 1) begin
                fails++; $display("FAIL rand_latency op %0d got %0d exp %0d", i, lat, W + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < D * 4; i++) begin
            mdl[i]   = 8'h00;
            known[i] = 1'b0;
        end
        test_reset();
        test_basic_access();
        test_rsp_hold();
        test_misalign();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's load/store interface: accepts one request per handshake and services byte, half and word accesses to an internal little-endian word array.
- Returns aligned, sign- or zero-extended read data after a programmable wait-state count.
- Sits between the datapath's load/store outputs and the data storage, and replaces the zero-latency data memory for multi-cycle CPU variants.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; must be a power of two.
- WAIT_CYCLES, 2, cycles spent in WAIT before the response; legal range 1..15.

Ports:
- SYS_clk  input  1  clock, all state updates on the rising edge
- SYS_reset_n  input  1  asynchronous active-low reset
- MEM_req_valid  input  1  request present
- MEM_req_ready  output  1  responder can accept a request
- MEM_req_write  input  1  1 = store, 0 = load
- MEM_address  input  32  byte address
- MEM_write_data  input  32  store data, right-justified
- MEM_write_length  input  2  01 byte, 10 half, 11 word, 00 no store
- MEM_read_length  input  2  01 byte, 10 half, 11 word; 00 is treated as word
- MEM_read_signed  input  1  sign-extend byte/half loads
- MEM_rsp_valid  output  1  response present
- MEM_rsp_ready  input  1  initiator takes the response
- MEM_read_data  output  32  load result; 0 for stores
- MEM_error  output  1  response flags a misaligned access (feature-dependent)

Behaviour:
- Reset (asynchronous, SYS_reset_n=0):
  - state=IDLE, wait counter=0.
  - MEM_req_ready=1, MEM_rsp_valid=0, MEM_read_data=0, MEM_error=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - MEM_req_ready=1.
  - On MEM_req_valid=1, the request is accepted: address, data, lengths, signedness and write flag are registered.
  - The counter loads WAIT_CYCLES-1 and the FSM moves to WAIT.
- WAIT:
  - MEM_req_ready=0 and the counter decrements.
  - At counter=0 the access is performed on that edge and the FSM moves to RESP.
  - Store: array write. Load: register the extracted data.
  - Latency from the acceptance edge to MEM_rsp_valid=1 is exactly WAIT_CYCLES+1 edges.
- RESP:
  - MEM_rsp_valid=1; MEM_read_data and MEM_error are stable.
  - Held until MEM_rsp_ready=1, then IDLE on that edge.
  - New requests are not accepted in RESP (MEM_req_ready=0); back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Word index = MEM_address[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4.
- Store lanes (little-endian):
  - Byte: write_data[7:0] goes to lane address[1:0].
  - Half: write_data[15:0] goes to lanes {address[1],0} and {address[1],1}.
  - Word: all lanes.
  - Length 00: no array change; a response is still returned.
- Load extraction:
  - Byte: lane address[1:0].
  - Half: lanes selected by address[1].
  - Result is zero-extended, or sign-extended from bit 7/15 when MEM_read_signed=1.
  - Word: full word.
- Misalignment is defined as half with address[0]=1, or word with address[1:0]!=0. Handling depends on the optional feature.
- Reset mid-operation: the FSM returns to IDLE immediately. A store not yet performed (still in WAIT) is discarded; a completed store persists.
- Simultaneous MEM_rsp_ready=1 and a new MEM_req_valid=1 in RESP: the response retires, and the request is accepted the following cycle in IDLE.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access is not performed (no array write, MEM_read_data=0).
  - Its response carries MEM_error=1.
- Undefined:
  - Low address bits are forced to alignment (half clears bit 0, word clears bits 1:0) and the access proceeds.
  - MEM_error is tied 0.

Decomposition:
- Shared package:
  - Length encodings: LEN_NONE=00, LEN_BYTE=01, LEN_HALF=10, LEN_WORD=11.
  - FSM state typedef.
- One sub-module, data_mem_lane_align: combinational byte-enable and store-data shifting, plus load extraction with sign/zero extension. It is reused by the instruction-fetch side later.

Test Plan:
- Reset, then store word 0xDEADBEEF to 0x10, then load word from 0x10 -> MEM_read_data=0xDEADBEEF, MEM_rsp_valid asserted exactly WAIT_CYCLES+1 edges after acceptance.
- After the above, store byte 0x7F to 0x13, then load byte signed from 0x13 -> 0x0000007F; then load word from 0x10 -> 0x7FADBEEF.
- Load byte signed from 0x10 -> 0xFFFFFFEF; load half unsigned from 0x12 -> 0x00007FAD.
- Hold MEM_rsp_ready=0 for 5 cycles in RESP -> MEM_rsp_valid and data stay stable, MEM_req_ready=0; release -> IDLE next edge.
- Store word to 0x11:
  - With DATA_MEM_MISALIGN_TRAP_EN: MEM_error=1 and word 0x10 is unchanged.
  - Without it: the write lands at 0x10 and MEM_error=0.
- Assert SYS_reset_n=0 during WAIT of a store to 0x20 -> outputs at reset values immediately; a later load from 0x20 returns the old contents.
